// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - seg7 scan constants, load FSM states and hex decoder
package seg7_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} load_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - prescaler emitting a one-cycle tick every TICK_DIV cycles
module scan_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-seg scan with frame-aligned loads
// Optional blinking is built only when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan_ctrl
  import seg7_scan_pkg::*;
#(
  parameter int unsigned NUM_DIG   = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [4*NUM_DIG-1:0]   i_digits,
  input  logic [NUM_DIG-1:0]     i_blank_mask,
  input  logic [NUM_DIG-1:0]     i_blink_mask,
  input  logic                   i_lzb,
  output logic [6:0]             o_seg,
  output logic [NUM_DIG-1:0]     o_an,
  output logic                   o_frame
);

  localparam int unsigned IW = $clog2(NUM_DIG);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);

  typedef struct packed {
    logic [4*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0]   blank;
    logic [NUM_DIG-1:0]   blink;
    logic                 lzb;
  } disp_cfg_t;

  logic              tick, frame_end;
  logic [IW-1:0]     idx_q, idx_d;
  load_state_e       state_q;
  logic              ready_q, frame_q, phase_q, phase_d;
  disp_cfg_t         shadow_q, shadow_d, pend_q, load_in;
  logic [6:0]        seg_q;
  logic [NUM_DIG-1:0] an_q;
  logic [3:0]        next_digit;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .tick_o (tick)
  );

  assign frame_end = tick && (idx_q == IDX_LAST);
  assign idx_d     = !tick ? idx_q : (frame_end ? '0 : idx_q + 1'b1);
  assign load_in   = '{digits: i_digits, blank: i_blank_mask, blink: i_blink_mask, lzb: i_lzb};

  // The slot being entered on a tick must see a commit landing on that same edge.
  always_comb begin
    shadow_d = shadow_q;
    if (frame_end) begin
      if (state_q == PEND) shadow_d = pend_q;
      else if (i_valid)    shadow_d = load_in;
    end
  end

  assign next_digit = shadow_d.digits[{idx_d, 2'b00} +: 4];

  function automatic logic digit_dark(input disp_cfg_t cfg, input logic [IW-1:0] k, input logic ph);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIG; j++)
      if (j >= int'(k) && cfg.digits[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    return cfg.blank[k] || (cfg.lzb && (k != '0) && upper_zero) || (cfg.blink[k] && ph);
  endfunction

`ifdef SEG7_SCAN_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt_q;

  assign phase_d = (frame_end && blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (frame_end) begin
      blink_cnt_q <= (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
      phase_q     <= phase_d;
    end
  end
`else
  assign phase_q = 1'b0;
  assign phase_d = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      pend_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid && !frame_end) begin
          pend_q  <= load_in;
          state_q <= PEND;
          ready_q <= 1'b0;
        end
        PEND: if (frame_end) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Anodes are released for one cycle on every tick so segments settle first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q    <= '0;
      frame_q  <= 1'b0;
      shadow_q <= '{digits: '0, blank: '1, blink: '0, lzb: 1'b0};
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      idx_q    <= idx_d;
      frame_q  <= frame_end;
      shadow_q <= shadow_d;
      if (tick) begin
        an_q  <= '1;
        seg_q <= digit_dark(shadow_d, idx_d, phase_d) ? SEG_BLANK : hex_to_seg(next_digit);
      end else begin
        an_q  <= digit_dark(shadow_q, idx_q, phase_q) ? '1 : ~(NUM_DIG'(1) << idx_q);
      end
    end
  end

  assign o_ready = ready_q;
  assign o_frame = frame_q;
  assign o_seg   = seg_q;
  assign o_an    = an_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the clock's multi-digit common-anode 7-segment display. It drives one shared active-low segment bus across `NUM_DIG` digit positions and steps through them at a programmable slot rate. It accepts new digit values from the time-keeping logic through a valid/ready handshake and applies them only on frame boundaries, so a refresh never shows digits from two different values. It also handles per-digit blanking, leading-zero blanking and optional blinking for time-set mode.

## Interface
- `NUM_DIG`, 4: number of digit positions, 2..8.
- `TICK_DIV`, 50000: clock cycles per digit slot, must be ≥ 2.
- `BLINK_DIV`, 25: frames per blink half-period, must be ≥ 1.

Ports:
- `i_clk`  in  1  single clock for the whole block.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  load request.
- `o_ready`  out  1  load accepted when `i_valid & o_ready`.
- `i_digits`  in  4*NUM_DIG  digit k on `[4k+3:4k]`; k=0 is least significant.
- `i_blank_mask`  in  NUM_DIG  1 = digit dark.
- `i_blink_mask`  in  NUM_DIG  1 = digit blinks.
- `i_lzb`  in  1  leading-zero blanking enable.
- `o_seg`  out  7  active-low segments, bit6=g … bit0=a.
- `o_an`  out  NUM_DIG  active-low digit enables.
- `o_frame`  out  1  one-cycle pulse at the end of each frame.

## Operation
- **Prescaler:** counts 0..TICK_DIV-1. `tick` is asserted when the count equals TICK_DIV-1, then the count wraps to 0.
- **Scan index:** `idx` runs 0..NUM_DIG-1, advances on `tick` and wraps to 0.
  - `frame_end` = `tick & (idx == NUM_DIG-1)`.
  - `o_frame` is the registered `frame_end`.
- **Load FSM, two states:**
  - IDLE, `o_ready`=1:
    - `i_valid` with `frame_end` in the same cycle: the load is written directly to the shadow registers; stay in IDLE.
    - `i_valid` without `frame_end`: capture into the pending registers; go to PEND.
  - PEND, `o_ready`=0:
    - `i_valid` is ignored.
    - On `frame_end`: shadow ← pending; go to IDLE.
  - The loaded set is `i_digits`, `i_blank_mask`, `i_blink_mask` and `i_lzb`. All four are captured together.
- **Decode:** standard active-low hex patterns.
  - Examples: 0=7'b1000000, 1=7'b1111001, 4=7'b0011001, 5=7'b0010010, 8=7'b0000000, F=7'b0001110.
  - Blank pattern = 7'b1111111.
- **Digit dark conditions:** a digit is dark if any of the following holds:
  - its shadow blank bit is set;
  - LZB is on, the digit is zero, and every more-significant digit is also zero (digit 0 is never LZB-blanked);
  - its blink bit is set and the blink phase is 1.
- **Dead time:** on `tick`, `o_an` is driven all ones and `o_seg` is loaded with the pattern for the new `idx`. In the next cycle, `o_an` = ~(1 << idx).

## Timing
- **Reset values** (asynchronous, effective immediately, including mid-operation):
  - outputs: `o_seg`=7'h7F, `o_an`=all ones, `o_ready`=1, `o_frame`=0;
  - internal: prescaler=0, `idx`=0, FSM=IDLE, blink phase=0, blink counter=0;
  - registers: shadow digits=0, shadow blank=all ones (display dark until the first load), pending registers cleared, pending data discarded.
- **After reset release:**
  - first `tick` occurs on cycle TICK_DIV-1;
  - frame period = NUM_DIG*TICK_DIV cycles;
  - each anode is low for TICK_DIV-1 cycles per slot.
- **Commit and ready timing:**
  - a load accepted in PEND is visible starting with slot 0 of the next frame;
  - `o_ready` rises in the cycle after the commit `frame_end`.
- **Outputs are registered:**
  - `o_seg` and `o_an` reflect `idx` with one cycle of latency;
  - `o_frame` rises one cycle after `frame_end`.
- **Blink:** the frame counter runs 0..BLINK_DIV-1 and toggles the blink phase on wrap. The phase changes only at `frame_end`.

## Configuration
- `SEG7_SCAN_BLINK_EN` defined: blink counter and blink phase are present; digits whose blink bit is set go dark during phase 1.
- Not defined: blink logic is removed, `i_blink_mask` is captured but ignored, and digits never blink.

## Structure
- Package `seg7_scan_pkg`:
  - the active-low hex pattern constants, `SEG_BLANK` = 7'h7F;
  - the FSM state enum (IDLE, PEND);
  - a `hex_to_seg` function.
- One sub-module, `scan_tick_gen`: parameterised prescaler producing the `tick` pulse. All remaining logic lives in the top module.

## Test plan
All scenarios use NUM_DIG=4, TICK_DIV=4, BLINK_DIV=2.
1. Reset with no load → `o_an`=4'b1111 and `o_seg`=7'h7F throughout; `o_frame` pulses every 16 cycles, first pulse at cycle 16.
2. Load `i_digits`=16'h1234, blank=0, mid-frame → from the next frame: `o_an`=4'b1110 with `o_seg`=7'b0011001; `o_an`=4'b0111 with `o_seg`=7'b1111001. One dead cycle with `o_an`=4'b1111 at every slot change.
3. Handshake → `o_ready` low from acceptance until the commit; a second `i_valid` in PEND is ignored; a load presented in the same cycle as `frame_end` in IDLE shows from the next frame with `o_ready` never falling.
4. LZB=1 with 16'h0050 → digits 3 and 2 dark, digit 1 shows 7'b0010010, digit 0 shows 7'b1000000. With 16'h0000 → only digit 0 lit.
5. Blink mask 4'b0001 with the macro defined → digit 0 lit for 2 frames, dark for 2 frames, repeating. Without the macro → always lit.
6. `i_rst_n` pulsed low mid-slot while in PEND → `o_an`=4'b1111, `o_seg`=7'h7F and `o_ready`=1 immediately; the pending value is never displayed.
